// File: rtl/pwm_spi_cfg.sv
// pwm_spi_cfg: SPI mode-0 slave that writes a bank of shadow PWM registers.
// The shadows are copied to the active outputs at a PWM period boundary.
// The SPI pins are asynchronous to clk. They are oversampled through 2-FF
// synchronizers, so clk must run at least 8x faster than spi_sck.
module pwm_spi_cfg (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic        period_end,
    output logic [31:0] duty_o,
    output logic [7:0]  period_o,
    output logic [3:0]  chan_en_o,
    output logic        cfg_update,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE,
        ST_WAIT
    } state_t;

    localparam logic [7:0] ID_VALUE = 8'hA5;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_sck_meta, r_sck_sync, r_sck_prev;
    logic        r_cs_meta,  r_cs_sync,  r_cs_prev;
    logic        r_mosi_meta, r_mosi_sync;

    logic [15:0] r_shift;
    logic [4:0]  r_bit_cnt;

    logic [31:0] r_duty,  r_sh_duty;
    logic [7:0]  r_period, r_sh_period;
    logic [3:0]  r_chan_en, r_sh_chan_en;
    logic        r_pending;
    logic        r_cfg_update;
    logic        r_frame_err;

    logic [7:0]  r_rd_sr;
    logic        r_rd_active;
    logic        r_miso;

    logic        w_sck_rise, w_sck_fall;
    logic        w_cs_rise,  w_cs_fall;
    logic [15:0] w_shift_nxt;
    logic [6:0]  w_hdr_addr;
    logic [7:0]  w_rd_byte;
    logic        w_commit_wr;
    logic        w_frame_abort;
    logic        w_load;

    // Synchronize the SPI pins into the clk domain and keep one delayed copy
    // for edge detection.
    // NOTE: sequential state is always assigned with <=. All flops then sample
    // the pre-edge values, and the synchronizer chain does not collapse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_meta  <= 1'b0;
            r_sck_sync  <= 1'b0;
            r_sck_prev  <= 1'b0;
            // The cs_n chain clears to "low". If cs_n is still low when reset
            // releases, no falling edge is seen, so a frame cut by reset is
            // never picked up halfway. cs_n must go high and then low again.
            r_cs_meta   <= 1'b0;
            r_cs_sync   <= 1'b0;
            r_cs_prev   <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_sck_meta  <= spi_sck;
            r_sck_sync  <= r_sck_meta;
            r_sck_prev  <= r_sck_sync;
            r_cs_meta   <= spi_cs_n;
            r_cs_sync   <= r_cs_meta;
            r_cs_prev   <= r_cs_sync;
            r_mosi_meta <= spi_mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    assign w_sck_rise  = r_sck_sync & ~r_sck_prev;
    assign w_sck_fall  = ~r_sck_sync & r_sck_prev;
    assign w_cs_rise   = r_cs_sync & ~r_cs_prev;
    assign w_cs_fall   = ~r_cs_sync & r_cs_prev;
    assign w_shift_nxt = {r_shift[14:0], r_mosi_sync};
    // Header byte {W, addr} as it will look after the 8th rising edge.
    assign w_hdr_addr  = w_shift_nxt[6:0];

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic for the frame sequencer.
    // NOTE: every combinational output gets a default before the case, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_cs_fall) w_state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_sck_rise && r_bit_cnt == 5'd15) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_WAIT;
            ST_WAIT:  if (r_cs_sync) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // A short frame is aborted only if at least one bit arrived. Writes to the
    // read-only or unmapped addresses are dropped and do not set pending.
    assign w_frame_abort = (r_state == ST_SHIFT) && w_cs_rise && (r_bit_cnt != 5'd0);
    assign w_commit_wr   = (r_state == ST_DONE) && r_shift[15] && (r_shift[14:8] <= 7'd5);
    assign w_load        = period_end && r_pending;

    // Shift register and saturating bit counter. Both restart on each frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (r_state == ST_IDLE && w_cs_fall) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (r_state == ST_SHIFT && w_sck_rise && !w_cs_rise) begin
            r_shift <= w_shift_nxt;
            if (r_bit_cnt != 5'd16) begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end
        end
    end

    // Read mux over the shadow bank, indexed by the header being received.
    always_comb begin
        w_rd_byte = 8'h00;
        case (w_hdr_addr)
            7'h00:   w_rd_byte = r_sh_duty[7:0];
            7'h01:   w_rd_byte = r_sh_duty[15:8];
            7'h02:   w_rd_byte = r_sh_duty[23:16];
            7'h03:   w_rd_byte = r_sh_duty[31:24];
            7'h04:   w_rd_byte = r_sh_period;
            7'h05:   w_rd_byte = {4'h0, r_sh_chan_en};
            7'h06:   w_rd_byte = ID_VALUE;
            7'h07:   w_rd_byte = {7'h00, r_pending};
            default: w_rd_byte = 8'h00;
        endcase
    end

    // Shadow writes, pending flag and copy of the shadows into the active
    // registers at the period boundary. A write that commits in the same clk
    // as the load loses the race: the old shadow is copied, and pending stays
    // set for the next boundary.
    // NOTE: this register bank is small enough to reset in full. The
    // shadow/active copies must agree at power-up, so nothing here is left
    // unreset the way a RAM array would be.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty       <= '0;
            r_period     <= 8'hFF;
            r_chan_en    <= '0;
            r_sh_duty    <= '0;
            r_sh_period  <= 8'hFF;
            r_sh_chan_en <= '0;
            r_pending    <= 1'b0;
            r_cfg_update <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_cfg_update <= w_load;
            r_frame_err  <= w_frame_abort;
            if (w_load) begin
                r_duty    <= r_sh_duty;
                r_period  <= r_sh_period;
                r_chan_en <= r_sh_chan_en;
            end
            if (w_commit_wr) begin
                case (r_shift[10:8])
                    3'd0:    r_sh_duty[7:0]   <= r_shift[7:0];
                    3'd1:    r_sh_duty[15:8]  <= r_shift[7:0];
                    3'd2:    r_sh_duty[23:16] <= r_shift[7:0];
                    3'd3:    r_sh_duty[31:24] <= r_shift[7:0];
                    3'd4:    r_sh_period      <= r_shift[7:0];
                    default: r_sh_chan_en     <= r_shift[3:0];
                endcase
            end
            if (w_commit_wr) begin
                r_pending <= 1'b1;
            end else if (w_load) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Read path. The addressed shadow byte is latched on the 8th rising edge.
    // It is then shifted out MSB first, one bit per falling edge, during data
    // bits 7:0. miso is 0 at every other time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_sr     <= '0;
            r_rd_active <= 1'b0;
            r_miso      <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_cs_fall) begin
                r_rd_active <= 1'b0;
            end else if (r_state == ST_SHIFT && w_sck_rise && !w_cs_rise &&
                         r_bit_cnt == 5'd7 && !w_shift_nxt[7]) begin
                r_rd_sr     <= w_rd_byte;
                r_rd_active <= 1'b1;
            end
            if (r_state == ST_SHIFT && !r_cs_sync && r_rd_active &&
                w_sck_fall && r_bit_cnt >= 5'd8) begin
                r_miso  <= r_rd_sr[7];
                r_rd_sr <= {r_rd_sr[6:0], 1'b0};
            end else if (r_state != ST_SHIFT || r_cs_sync) begin
                r_miso <= 1'b0;
            end
        end
    end

    assign spi_miso   = r_miso;
    assign duty_o     = r_duty;
    assign period_o   = r_period;
    assign chan_en_o  = r_chan_en;
    assign cfg_update = r_cfg_update;
    assign frame_err  = r_frame_err;

endmodule
